// File: rtl/int_to_fp_converter.sv
// ---------------------------------------------------------------------------
// int_to_fp_converter
//   Three-stage pipelined integer to floating-point converter. It takes a
//   signed or unsigned integer and produces a packed {sign, exponent, fraction}
//   value with IEEE-style rounding. The defaults produce fp32.
//
//   Stages: S1 sign/magnitude capture, S2 leading-one search and left
//   normalise, S3 round and pack. One advance enable moves all stages
//   together, so a stalled output holds the whole pipeline.
//
// Parameters
//   INT_WIDTH  : integer operand width (32 or 64)
//   EXP_WIDTH  : result exponent width
//   FRAC_WIDTH : result fraction width
//
// Ports
//   clk         : clock, all state on rising edge
//   rst         : synchronous active-high reset
//   in_valid    : operand present
//   in_ready    : operand accepted when high together with in_valid
//   in_value    : integer operand
//   in_unsigned : 1 = unsigned operand, 0 = two's-complement signed
//   in_rm       : rounding mode 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM (5-7 = RNE)
//   out_valid   : result present
//   out_ready   : consumer accepts result
//   out_flags   : {NV, DZ, OF, UF, NX}, only when RAFI_FCVT_FLAGS_EN is defined
//   out_value   : packed {sign, exponent, fraction}
//
// Build option
//   RAFI_FCVT_FLAGS_EN : adds out_flags and the inexact tracking registers.
// ---------------------------------------------------------------------------
module int_to_fp_converter #(
  parameter int INT_WIDTH  = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_WIDTH-1:0]          in_value,
  input  logic                          in_unsigned,
  input  logic [2:0]                    in_rm,
  output logic                          out_valid,
  input  logic                          out_ready,
`ifdef RAFI_FCVT_FLAGS_EN
  output logic [4:0]                    out_flags,
`endif
  output logic [EXP_WIDTH+FRAC_WIDTH:0] out_value
);

  localparam int POS_W = $clog2(INT_WIDTH);
  localparam int BIAS  = (1 << (EXP_WIDTH - 1)) - 1;
  // Normalised body (bits below the leading one) padded so the guard bit
  // always exists, even if FRAC_WIDTH is wider than the operand.
  localparam int EXT_W = INT_WIDTH + FRAC_WIDTH + 1;

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // The largest exponent reachable is BIAS + INT_WIDTH - 1, so requiring
  // BIAS >= INT_WIDTH rules out overflow even after a rounding carry.
  if ((BIAS < INT_WIDTH) || ((INT_WIDTH != 32) && (INT_WIDTH != 64))) begin : g_param_check
    $error("int_to_fp_converter: unsupported INT_WIDTH/EXP_WIDTH combination");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: sign / magnitude ----------------
  logic                 s1_valid, s1_sign;
  logic [INT_WIDTH-1:0] s1_mag;
  logic [2:0]           s1_rm;
  logic                 in_sign;

  assign in_sign = !in_unsigned && in_value[INT_WIDTH-1];

  // Negating the most negative value wraps back to 2^(INT_WIDTH-1), which
  // is exactly the correct unsigned magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= in_sign;
      s1_mag   <= in_sign ? -in_value : in_value;
      s1_rm    <= in_rm;
    end
  end

  // ---------------- S2: leading-one search and normalise ----------------
  logic [POS_W-1:0]     lead_pos;
  logic [INT_WIDTH-1:0] norm;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < INT_WIDTH; i++) begin
      if (s1_mag[i]) lead_pos = POS_W'(i);
    end
  end

  assign norm = s1_mag << (POS_W'(INT_WIDTH - 1) - lead_pos);

  logic                 s2_valid, s2_sign, s2_nonzero;
  logic [INT_WIDTH-2:0] s2_body;
  logic [POS_W-1:0]     s2_pos;
  logic [2:0]           s2_rm;

  // After normalising, the top bit is set for any nonzero magnitude, so it
  // doubles as the zero detector and the implicit one is not stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_nonzero <= norm[INT_WIDTH-1];
      s2_body    <= norm[INT_WIDTH-2:0];
      s2_pos     <= lead_pos;
      s2_rm      <= s1_rm;
    end
  end

  // ---------------- S3: round and pack ----------------
  logic [EXT_W-1:0]            ext;
  logic [FRAC_WIDTH-1:0]       frac;
  logic                        guard, sticky, inexact, round_up;
  logic [FRAC_WIDTH:0]         frac_sum;
  logic [EXP_WIDTH-1:0]        exp_final;
  logic [EXP_WIDTH+FRAC_WIDTH:0] packed_value;

  assign ext     = {s2_body, {(FRAC_WIDTH + 2){1'b0}}};
  assign frac    = ext[EXT_W-1 -: FRAC_WIDTH];
  assign guard   = ext[EXT_W-1-FRAC_WIDTH];
  assign sticky  = |ext[EXT_W-2-FRAC_WIDTH:0];
  assign inexact = guard || sticky;

  always_comb begin
    round_up = 1'b0;
    case (s2_rm)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = s2_sign && inexact;
      RM_RUP:  round_up = !s2_sign && inexact;
      RM_RMM:  round_up = guard;
      default: round_up = guard && (sticky || frac[0]);
    endcase
  end

  // A carry out of the fraction leaves the low bits all zero, so only the
  // exponent needs the extra increment.
  assign frac_sum  = {1'b0, frac} + {{FRAC_WIDTH{1'b0}}, round_up};
  assign exp_final = EXP_WIDTH'(s2_pos) + EXP_WIDTH'(BIAS)
                   + {{(EXP_WIDTH-1){1'b0}}, frac_sum[FRAC_WIDTH]};
  assign packed_value = s2_nonzero ? {s2_sign, exp_final, frac_sum[FRAC_WIDTH-1:0]} : '0;

  // Bubbles load zero so out_value reads 0 whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_value <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_value <= s2_valid ? packed_value : '0;
    end
  end

`ifdef RAFI_FCVT_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags <= '0;
    end else if (adv) begin
      out_flags <= {4'b0000, s2_valid && s2_nonzero && inexact};
    end
  end
`endif

endmodule

// File: tb/tb_int_to_fp_converter.sv
// ---------------------------------------------------------------------------
// tb_int_to_fp_converter
//   Directed self-checking bench. Drives a 32-bit default instance and a
//   64-bit instance with hand-computed vectors, then exercises output
//   back-pressure and a mid-flight reset on the 32-bit instance.
// ---------------------------------------------------------------------------
module tb_int_to_fp_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_in_valid, a_in_ready, a_in_unsigned, a_out_valid, a_out_ready;
  logic [31:0] a_in_value;
  logic [2:0]  a_in_rm;
  logic [31:0] a_out_value;

  logic        b_in_valid, b_in_ready, b_in_unsigned, b_out_valid, b_out_ready;
  logic [63:0] b_in_value;
  logic [2:0]  b_in_rm;
  logic [31:0] b_out_value;

`ifdef RAFI_FCVT_FLAGS_EN
  logic [4:0] a_out_flags, b_out_flags;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] stall_exp [4];
  int          sent, got, stall_left;
  logic        seen_first;

  int_to_fp_converter #(.INT_WIDTH(32), .EXP_WIDTH(8), .FRAC_WIDTH(23)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .in_value    (a_in_value),
    .in_unsigned (a_in_unsigned),
    .in_rm       (a_in_rm),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
`ifdef RAFI_FCVT_FLAGS_EN
    .out_flags   (a_out_flags),
`endif
    .out_value   (a_out_value)
  );

  int_to_fp_converter #(.INT_WIDTH(64), .EXP_WIDTH(8), .FRAC_WIDTH(23)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .in_value    (b_in_value),
    .in_unsigned (b_in_unsigned),
    .in_rm       (b_in_rm),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
`ifdef RAFI_FCVT_FLAGS_EN
    .out_flags   (b_out_flags),
`endif
    .out_value   (b_out_value)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one operand for a single cycle to the selected instance.
  task automatic applyStimulus(input logic sel64, input logic [63:0] value,
                               input logic uns, input logic [2:0] rm);
    @(negedge clk);
    if (sel64) begin
      b_in_valid = 1'b1; b_in_value = value; b_in_unsigned = uns; b_in_rm = rm;
    end else begin
      a_in_valid = 1'b1; a_in_value = value[31:0]; a_in_unsigned = uns; a_in_rm = rm;
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  // Waits (bounded) for the result, then checks latency, value and NX.
  task automatic waitResult(input logic sel64, input string tag,
                            input logic [31:0] expected, input logic nx);
    int   lat;
    logic v;
    lat = 1;
    v   = sel64 ? b_out_valid : a_out_valid;
    while (!v && lat < 8) begin
      @(negedge clk);
      lat++;
      v = sel64 ? b_out_valid : a_out_valid;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd3);
    checkOutput(tag, {32'b0, (sel64 ? b_out_value : a_out_value)}, {32'b0, expected});
`ifdef RAFI_FCVT_FLAGS_EN
    checkOutput({tag, "_flags"}, {59'b0, (sel64 ? b_out_flags : a_out_flags)}, {59'b0, 4'b0000, nx});
`endif
    $display("[TB] case %s done (expected NX=%0d)", tag, nx);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_value = '0; a_in_unsigned = 1'b0; a_in_rm = 3'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_value = '0; b_in_unsigned = 1'b0; b_in_rm = 3'd0; b_out_ready = 1'b1;
    stall_exp[0] = 32'h3F800000; stall_exp[1] = 32'h40000000;
    stall_exp[2] = 32'h40400000; stall_exp[3] = 32'h40800000;

    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid",   {63'b0, a_out_valid}, 64'd0);
    checkOutput("reset_out_value",   {32'b0, a_out_value}, 64'd0);
    checkOutput("reset_in_ready",    {63'b0, a_in_ready},  64'd1);
    checkOutput("reset_out_valid64", {63'b0, b_out_valid}, 64'd0);
    checkOutput("reset_in_ready64",  {63'b0, b_in_ready},  64'd1);
    rst = 1'b0;

    applyStimulus(0, 64'hFFFFFFFF, 0, 3'd0); waitResult(0, "neg_one",         32'hBF800000, 0);
    applyStimulus(0, 64'h80000000, 0, 3'd0); waitResult(0, "int_min",         32'hCF000000, 0);
    applyStimulus(0, 64'h80000000, 1, 3'd0); waitResult(0, "u_two_pow31",     32'h4F000000, 0);
    applyStimulus(0, 64'h01000001, 1, 3'd0); waitResult(0, "u_tie_rne",       32'h4B800000, 1);
    applyStimulus(0, 64'h01000001, 1, 3'd3); waitResult(0, "u_tie_rup",       32'h4B800001, 1);
    applyStimulus(0, 64'h01000001, 1, 3'd4); waitResult(0, "u_tie_rmm",       32'h4B800001, 1);
    applyStimulus(0, 64'h01000001, 1, 3'd1); waitResult(0, "u_tie_rtz",       32'h4B800000, 1);
    applyStimulus(0, 64'h01000001, 1, 3'd5); waitResult(0, "rm5_as_rne",      32'h4B800000, 1);
    applyStimulus(0, 64'h01000003, 1, 3'd0); waitResult(0, "odd_tie_rne",     32'h4B800002, 1);
    applyStimulus(0, 64'h01000003, 1, 3'd7); waitResult(0, "rm7_as_rne",      32'h4B800002, 1);
    applyStimulus(0, 64'h00000000, 0, 3'd2); waitResult(0, "zero_rdn",        32'h00000000, 0);
    applyStimulus(0, 64'h00000000, 1, 3'd3); waitResult(0, "zero_u_rup",      32'h00000000, 0);
    applyStimulus(0, 64'h00000005, 0, 3'd0); waitResult(0, "pos_five",        32'h40A00000, 0);
    applyStimulus(0, 64'hFFFFFFFB, 0, 3'd2); waitResult(0, "neg_five_rdn",    32'hC0A00000, 0);
    applyStimulus(0, 64'hFEFFFFFF, 0, 3'd2); waitResult(0, "neg_inexact_rdn", 32'hCB800001, 1);
    applyStimulus(0, 64'hFEFFFFFF, 0, 3'd3); waitResult(0, "neg_inexact_rup", 32'hCB800000, 1);
    applyStimulus(0, 64'hFFFFFFFF, 1, 3'd1); waitResult(0, "umax_rtz",        32'h4F7FFFFF, 1);
    applyStimulus(0, 64'hFFFFFFFF, 1, 3'd0); waitResult(0, "umax_rne",        32'h4F800000, 1);

    applyStimulus(1, 64'hFFFFFFFFFFFFFFFF, 1, 3'd1); waitResult(1, "w64_umax_rtz", 32'h5F7FFFFF, 1);
    applyStimulus(1, 64'hFFFFFFFFFFFFFFFF, 1, 3'd0); waitResult(1, "w64_umax_rne", 32'h5F800000, 1);
    applyStimulus(1, 64'hFFFFFFFFFFFFFFFF, 0, 3'd0); waitResult(1, "w64_neg_one",  32'hBF800000, 0);
    applyStimulus(1, 64'h8000000000000000, 0, 3'd0); waitResult(1, "w64_int_min",  32'hDF000000, 0);

    // Back-to-back stream of 1,2,3,4 with a 5-cycle output stall.
    sent = 0; got = 0; stall_left = 0; seen_first = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (a_out_valid && !seen_first) begin
        seen_first = 1'b1;
        stall_left = 5;
      end
      a_out_ready = (stall_left == 0);
      if (sent < 4) begin
        a_in_valid = 1'b1; a_in_value = 32'(sent + 1); a_in_unsigned = 1'b0; a_in_rm = 3'd0;
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        checkOutput("stall_in_ready", {63'b0, a_in_ready}, 64'd0);
        checkOutput("stall_hold", {32'b0, a_out_value}, {32'b0, stall_exp[0]});
        stall_left--;
      end
      if (a_out_valid && a_out_ready) begin
        if (got < 4) checkOutput($sformatf("stream_%0d", got), {32'b0, a_out_value}, {32'b0, stall_exp[got]});
        else checkOutput("stream_extra_result", {63'b0, a_out_valid}, 64'd0);
        got++;
      end
      if (a_in_valid && a_in_ready) sent++;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    checkOutput("stream_count", 64'(got), 64'd4);
    checkOutput("stream_sent",  64'(sent), 64'd4);

    // Mid-flight reset with two operands in the pipe and one offered during rst.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_value = 32'd7;  a_in_unsigned = 1'b0; a_in_rm = 3'd0;
    @(negedge clk);
    a_in_value = 32'd9;
    @(negedge clk);
    a_in_value = 32'd11;
    rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", {63'b0, a_in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    a_in_valid = 1'b0;
    checkOutput("rst_out_value_zero", {32'b0, a_out_value}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rst_flush_%0d", k), {63'b0, a_out_valid}, 64'd0);
      @(negedge clk);
    end
    applyStimulus(0, 64'hFFFFFFFD, 0, 3'd0); waitResult(0, "after_rst_neg_three", 32'hC0400000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
